// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, drives instruction memory and loads the IF/ID register.
// A stall freezes the whole stage and a flush turns the IF/ID contents into a bubble.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h00000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic [1:0]  pc_src,
    input  logic [31:0] branch_target,
    input  logic [31:0] jump_target,
    input  logic [31:0] jr_target,
    input  logic [31:0] imem_inst,
    output logic [31:0] imem_addr,
    output logic [31:0] ifid_inst,
    output logic [31:0] ifid_pc_plus4,
    output logic        ifid_valid,
    output logic        misalign_err,
    output logic [31:0] fetch_count
);

    typedef enum logic {
        ADVANCE = 1'b0,
        HOLD    = 1'b1
    } mode_e;

    mode_e       mode;

    logic [31:0] pc_q, pc_d;
    logic [31:0] ifidInst_q, ifidInst_d;
    logic [31:0] ifidPcPlus4_q, ifidPcPlus4_d;
    logic        ifidValid_q, ifidValid_d;
    logic        misalign_q, misalign_d;
    logic [31:0] fetchCount_q, fetchCount_d;

    logic [31:0] pcPlus4;
    logic [31:0] redirectTarget;
    logic        redirect;

    always_comb begin
        pcPlus4        = pc_q + 32'd4;
        redirect       = (pc_src != 2'b00);
        redirectTarget = 32'h00000000;
        case (pc_src)
            2'b01:   redirectTarget = branch_target;
            2'b10:   redirectTarget = jump_target;
            2'b11:   redirectTarget = jr_target;
            default: redirectTarget = 32'h00000000;
        endcase
    end

    // HOLD is decided each cycle from stall alone; no stall history is kept.
    always_comb begin
        mode          = stall ? HOLD : ADVANCE;
        pc_d          = pc_q;
        ifidInst_d    = ifidInst_q;
        ifidPcPlus4_d = ifidPcPlus4_q;
        ifidValid_d   = ifidValid_q;
        misalign_d    = misalign_q;
        fetchCount_d  = fetchCount_q;

        case (mode)
            ADVANCE: begin
                pc_d       = redirect ? {redirectTarget[31:2], 2'b00} : pcPlus4;
                misalign_d = misalign_q | (redirect & (redirectTarget[1:0] != 2'b00));
                if (flush) begin
                    ifidInst_d    = 32'h00000000;
                    ifidPcPlus4_d = 32'h00000000;
                    ifidValid_d   = 1'b0;
                end else begin
                    ifidInst_d    = imem_inst;
                    ifidPcPlus4_d = pcPlus4;
                    ifidValid_d   = 1'b1;
                    fetchCount_d  = fetchCount_q + 32'd1;
                end
            end
            HOLD: begin
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q          <= RESET_PC;
            ifidInst_q    <= 32'h00000000;
            ifidPcPlus4_q <= 32'h00000000;
            ifidValid_q   <= 1'b0;
            misalign_q    <= 1'b0;
            fetchCount_q  <= 32'h00000000;
        end else begin
            pc_q          <= pc_d;
            ifidInst_q    <= ifidInst_d;
            ifidPcPlus4_q <= ifidPcPlus4_d;
            ifidValid_q   <= ifidValid_d;
            misalign_q    <= misalign_d;
            fetchCount_q  <= fetchCount_d;
        end
    end

    assign imem_addr     = pc_q;
    assign ifid_inst     = ifidInst_q;
    assign ifid_pc_plus4 = ifidPcPlus4_q;
    assign ifid_valid    = ifidValid_q;
    assign misalign_err  = misalign_q;
    assign fetch_count   = fetchCount_q;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: reset, fetch, redirects, flush, stall, misalignment, PC wrap, async reset.
// Instruction memory returns 32'h20042f5b at address 0 and (addr ^ 32'hC0DE0000) elsewhere.
module tb_if_stage;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        flush;
    logic [1:0]  pc_src;
    logic [31:0] branch_target;
    logic [31:0] jump_target;
    logic [31:0] jr_target;
    logic [31:0] imem_inst;
    logic [31:0] imem_addr;
    logic [31:0] ifid_inst;
    logic [31:0] ifid_pc_plus4;
    logic        ifid_valid;
    logic        misalign_err;
    logic [31:0] fetch_count;

    int nCompared   = 0;
    int nMismatched = 0;

    if_stage #(.RESET_PC(32'h00000000)) dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .flush         (flush),
        .pc_src        (pc_src),
        .branch_target (branch_target),
        .jump_target   (jump_target),
        .jr_target     (jr_target),
        .imem_inst     (imem_inst),
        .imem_addr     (imem_addr),
        .ifid_inst     (ifid_inst),
        .ifid_pc_plus4 (ifid_pc_plus4),
        .ifid_valid    (ifid_valid),
        .misalign_err  (misalign_err),
        .fetch_count   (fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign imem_inst = (imem_addr == 32'h0) ? 32'h20042f5b : (imem_addr ^ 32'hC0DE0000);

    // Advance one rising edge and sample 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; stall = 1'b0; flush = 1'b0; pc_src = 2'b00;
        branch_target = '0; jump_target = '0; jr_target = '0;
        #23;
        nCompared++;
        if (imem_addr !== 32'h0) begin nMismatched++; $display("[TB] FAIL reset_pc actual=%h required=%h", imem_addr, 32'h0); end
        nCompared++;
        if ({ifid_inst, ifid_pc_plus4, fetch_count} !== 96'h0) begin nMismatched++; $display("[TB] FAIL reset_ifid actual=%h/%h/%h required=0/0/0", ifid_inst, ifid_pc_plus4, fetch_count); end
        nCompared++;
        if ({ifid_valid, misalign_err} !== 2'b00) begin nMismatched++; $display("[TB] FAIL reset_flags actual=%b%b required=00", ifid_valid, misalign_err); end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_first_fetch();
        step();
        nCompared++;
        if (imem_addr !== 32'h4) begin nMismatched++; $display("[TB] FAIL first_pc actual=%h required=%h", imem_addr, 32'h4); end
        nCompared++;
        if (ifid_inst !== 32'h20042f5b) begin nMismatched++; $display("[TB] FAIL first_inst actual=%h required=%h", ifid_inst, 32'h20042f5b); end
        nCompared++;
        if ({ifid_pc_plus4, ifid_valid, fetch_count} !== {32'h4, 1'b1, 32'h1}) begin nMismatched++; $display("[TB] FAIL first_ifid actual=%h/%b/%h required=4/1/1", ifid_pc_plus4, ifid_valid, fetch_count); end
    endtask

    task automatic test_jump_flush();
        pc_src = 2'b10; jump_target = 32'h00000034;
        step();
        nCompared++;
        if (imem_addr !== 32'h34) begin nMismatched++; $display("[TB] FAIL jump_pc actual=%h required=%h", imem_addr, 32'h34); end
        nCompared++;
        if ({ifid_inst, ifid_pc_plus4, fetch_count} !== {32'hC0DE0004, 32'h8, 32'h2}) begin nMismatched++; $display("[TB] FAIL jump_ifid actual=%h/%h/%h required=c0de0004/8/2", ifid_inst, ifid_pc_plus4, fetch_count); end
        pc_src = 2'b00; flush = 1'b1;
        step();
        flush = 1'b0;
        nCompared++;
        if (imem_addr !== 32'h38) begin nMismatched++; $display("[TB] FAIL flush_pc actual=%h required=%h", imem_addr, 32'h38); end
        nCompared++;
        if ({ifid_inst, ifid_pc_plus4, ifid_valid, fetch_count} !== {32'h0, 32'h0, 1'b0, 32'h2}) begin nMismatched++; $display("[TB] FAIL flush_ifid actual=%h/%h/%b/%h required=0/0/0/2", ifid_inst, ifid_pc_plus4, ifid_valid, fetch_count); end
    endtask

    // Stall with redirects requested (some misaligned, flush also high) must change nothing.
    task automatic test_stall();
        stall = 1'b1; flush = 1'b1; pc_src = 2'b01; branch_target = 32'h0000001E; jr_target = 32'h00000003;
        for (int i = 0; i < 3; i++) begin
            if (i == 2) branch_target = 32'h0000001C;
            step();
            nCompared++;
            if ({imem_addr, ifid_inst, ifid_valid, fetch_count, misalign_err} !== {32'h38, 32'h0, 1'b0, 32'h2, 1'b0})
                begin nMismatched++; $display("[TB] FAIL stall_hold%0d actual=%h/%h/%b/%h/%b required=38/0/0/2/0", i, imem_addr, ifid_inst, ifid_valid, fetch_count, misalign_err); end
        end
        stall = 1'b0; flush = 1'b0;
        step();
        nCompared++;
        if (imem_addr !== 32'h1C) begin nMismatched++; $display("[TB] FAIL stall_release_pc actual=%h required=%h", imem_addr, 32'h1C); end
        nCompared++;
        if ({ifid_inst, ifid_pc_plus4, ifid_valid, fetch_count} !== {32'hC0DE0038, 32'h3C, 1'b1, 32'h3}) begin nMismatched++; $display("[TB] FAIL stall_release_ifid actual=%h/%h/%b/%h required=c0de0038/3c/1/3", ifid_inst, ifid_pc_plus4, ifid_valid, fetch_count); end
        nCompared++;
        if (misalign_err !== 1'b0) begin nMismatched++; $display("[TB] FAIL unselected_misalign actual=%b required=0", misalign_err); end
    endtask

    task automatic test_misalign();
        pc_src = 2'b01; branch_target = 32'h0000001E;
        step();
        nCompared++;
        if ({imem_addr, misalign_err} !== {32'h1C, 1'b1}) begin nMismatched++; $display("[TB] FAIL misalign_set actual=%h/%b required=1c/1", imem_addr, misalign_err); end
        pc_src = 2'b00;
        for (int i = 0; i < 10; i++) begin
            step();
            nCompared++;
            if (misalign_err !== 1'b1) begin nMismatched++; $display("[TB] FAIL misalign_sticky%0d actual=%b required=1", i, misalign_err); end
        end
        nCompared++;
        if ({imem_addr, fetch_count} !== {32'h44, 32'd14}) begin nMismatched++; $display("[TB] FAIL run_after_misalign actual=%h/%0d required=44/14", imem_addr, fetch_count); end
    endtask

    task automatic test_pc_wrap();
        pc_src = 2'b11; jr_target = 32'hFFFFFFFC;
        step();
        nCompared++;
        if (imem_addr !== 32'hFFFFFFFC) begin nMismatched++; $display("[TB] FAIL jr_pc actual=%h required=%h", imem_addr, 32'hFFFFFFFC); end
        pc_src = 2'b00;
        step();
        nCompared++;
        if (imem_addr !== 32'h0) begin nMismatched++; $display("[TB] FAIL wrap_pc actual=%h required=%h", imem_addr, 32'h0); end
        nCompared++;
        if ({ifid_inst, ifid_pc_plus4, ifid_valid, fetch_count} !== {32'h3F21FFFC, 32'h0, 1'b1, 32'd16}) begin nMismatched++; $display("[TB] FAIL wrap_ifid actual=%h/%h/%b/%0d required=3f21fffc/0/1/16", ifid_inst, ifid_pc_plus4, ifid_valid, fetch_count); end
    endtask

    // Reset dropped between edges must clear everything without a clock edge.
    task automatic test_async_reset();
        step();
        #2;
        reset = 1'b0;
        #1;
        nCompared++;
        if ({imem_addr, ifid_inst, ifid_pc_plus4, fetch_count} !== 128'h0) begin nMismatched++; $display("[TB] FAIL async_reset_regs actual=%h/%h/%h/%h required=0/0/0/0", imem_addr, ifid_inst, ifid_pc_plus4, fetch_count); end
        nCompared++;
        if ({ifid_valid, misalign_err} !== 2'b00) begin nMismatched++; $display("[TB] FAIL async_reset_flags actual=%b%b required=00", ifid_valid, misalign_err); end
        @(negedge clk);
        reset = 1'b1;
        step();
        nCompared++;
        if ({imem_addr, ifid_inst, fetch_count} !== {32'h4, 32'h20042f5b, 32'h1}) begin nMismatched++; $display("[TB] FAIL refetch actual=%h/%h/%h required=4/20042f5b/1", imem_addr, ifid_inst, fetch_count); end
    endtask

    initial begin
        test_reset();
        test_first_fetch();
        test_jump_flush();
        test_stall();
        test_misalign();
        test_pc_wrap();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
